// File: rtl/subservient_dbg_loader_if.sv
// ---------------------------------------------------------------------------
// subservient_dbg_loader_if
// Wishbone classic bus between the firmware loader (initiator) and the
// subservient debug port (responder). Signal names keep the initiator's
// point of view (_o driven by the loader, _i driven by the responder).
//
//   wbm_cyc_o  cycle            wbm_stb_o  strobe
//   wbm_we_o   write enable     wbm_sel_o  byte selects (always all lanes)
//   wbm_adr_o  byte address     wbm_dat_o  write data
//   wbm_dat_i  read data        wbm_ack_i  acknowledge
//
// Modports: master = loader side, slave = debug-port / responder side.
// ---------------------------------------------------------------------------
interface subservient_dbg_loader_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/subservient_dbg_loader.sv
// ---------------------------------------------------------------------------
// subservient_dbg_loader
// Loads a firmware image into the subservient core's SRAM through its debug
// port, then releases debug mode so the core boots.
//
// A byte stream (valid/ready) is packed little-endian into 32-bit words; each
// word is written with one single-beat Wishbone classic write, starting at
// BASE_ADR and stepping by 4. After NUM_WORDS words the core is released.
// A write (or read) that is not acknowledged within TIMEOUT cycles aborts
// the load and keeps the core in debug mode.
//
// Optional build macro LOADER_VERIFY_EN: after the last write the image is
// read back, and the XOR of the read words must equal the XOR of the written
// words before the core is released; otherwise the load ends in error.
//
// Ports:
//   wb_clk_i      clock
//   wb_rst_ni     synchronous reset, active low
//   start_i       one-cycle start pulse (ignored while busy)
//   s_byte_i      stream byte
//   s_valid_i     stream byte valid
//   s_ready_o     loader accepts a byte (decoded from the state)
//   wbm           Wishbone initiator bus (subservient_dbg_loader_if.master)
//   debug_mode_o  1 = core held in debug mode
//   busy_o        load in progress
//   done_o        image loaded and core released
//   error_o       load aborted
//
// Parameters:
//   NUM_WORDS  words per image
//   BASE_ADR   byte address of the first word (4-byte aligned)
//   TIMEOUT    cycles to wait for an acknowledge, 1..255
// ---------------------------------------------------------------------------
module subservient_dbg_loader #(
    parameter int unsigned NUM_WORDS = 128,
    parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_ni,
    input  logic                            start_i,
    input  logic [7:0]                      s_byte_i,
    input  logic                            s_valid_i,
    output logic                            s_ready_o,
    subservient_dbg_loader_if.master        wbm,
    output logic                            debug_mode_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            error_o
);

    localparam int unsigned CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
`ifdef LOADER_VERIFY_EN
        , ST_VERIFY = 3'd5
`endif
    } state_t;

    state_t           state_r;
    logic [1:0]       idx_r;
    logic [CNT_W-1:0] word_cnt_r;
    logic [7:0]       timeout_r;

`ifdef LOADER_VERIFY_EN
    logic [31:0]      wr_sum_r;
    logic [31:0]      rd_sum_r;
`else
    // Read data is only consumed by the read-back check.
    logic             unused_dat_s;
    assign unused_dat_s = ^wbm.wbm_dat_i;
`endif

    // Stream is accepted only while gathering the bytes of a word.
    assign s_ready_o = (state_r == ST_COLLECT);

    // Load sequencer: owns the state, counters and every registered output.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_r       <= ST_IDLE;
            idx_r         <= 2'd0;
            word_cnt_r    <= {CNT_W{1'b0}};
            timeout_r     <= 8'd0;
            wbm.wbm_cyc_o <= 1'b0;
            wbm.wbm_stb_o <= 1'b0;
            wbm.wbm_we_o  <= 1'b0;
            wbm.wbm_sel_o <= 4'hF;
            wbm.wbm_adr_o <= BASE_ADR;
            wbm.wbm_dat_o <= 32'h0000_0000;
            debug_mode_o  <= 1'b1;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
`ifdef LOADER_VERIFY_EN
            wr_sum_r      <= 32'h0000_0000;
            rd_sum_r      <= 32'h0000_0000;
`endif
        end else begin
            wbm.wbm_sel_o <= 4'hF;
            case (state_r)
                // A start from idle, or after a finished/aborted load,
                // begins a fresh image at the base address.
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_i) begin
                        state_r       <= ST_COLLECT;
                        idx_r         <= 2'd0;
                        word_cnt_r    <= {CNT_W{1'b0}};
                        timeout_r     <= 8'd0;
                        wbm.wbm_adr_o <= BASE_ADR;
                        debug_mode_o  <= 1'b1;
                        busy_o        <= 1'b1;
                        done_o        <= 1'b0;
                        error_o       <= 1'b0;
`ifdef LOADER_VERIFY_EN
                        wr_sum_r      <= 32'h0000_0000;
                        rd_sum_r      <= 32'h0000_0000;
`endif
                    end
                end

                // Bytes land directly in the write-data register, lane idx.
                ST_COLLECT: begin
                    if (s_valid_i) begin
                        wbm.wbm_dat_o[{idx_r, 3'b000} +: 8] <= s_byte_i;
                        idx_r <= idx_r + 2'd1;
                        if (idx_r == 2'd3) begin
                            state_r       <= ST_WRITE;
                            wbm.wbm_cyc_o <= 1'b1;
                            wbm.wbm_stb_o <= 1'b1;
                            wbm.wbm_we_o  <= 1'b1;
                            timeout_r     <= 8'd0;
                        end
                    end
                end

                ST_WRITE: begin
                    if (wbm.wbm_ack_i) begin
                        wbm.wbm_cyc_o <= 1'b0;
                        wbm.wbm_stb_o <= 1'b0;
`ifdef LOADER_VERIFY_EN
                        wr_sum_r <= wr_sum_r ^ wbm.wbm_dat_o;
`endif
                        if (word_cnt_r == LAST_WORD) begin
`ifdef LOADER_VERIFY_EN
                            // Read-back starts again from the first word.
                            state_r       <= ST_VERIFY;
                            word_cnt_r    <= {CNT_W{1'b0}};
                            wbm.wbm_adr_o <= BASE_ADR;
                            wbm.wbm_we_o  <= 1'b0;
`else
                            state_r       <= ST_DONE;
                            wbm.wbm_adr_o <= wbm.wbm_adr_o + 32'd4;
                            debug_mode_o  <= 1'b0;
                            busy_o        <= 1'b0;
                            done_o        <= 1'b1;
`endif
                        end else begin
                            state_r       <= ST_COLLECT;
                            word_cnt_r    <= word_cnt_r + CNT_W'(1);
                            wbm.wbm_adr_o <= wbm.wbm_adr_o + 32'd4;
                        end
                    end else if (timeout_r == TO_LAST) begin
                        // The strobe has been up for TIMEOUT cycles.
                        state_r       <= ST_ERROR;
                        wbm.wbm_cyc_o <= 1'b0;
                        wbm.wbm_stb_o <= 1'b0;
                        busy_o        <= 1'b0;
                        error_o       <= 1'b1;
                    end else begin
                        timeout_r <= timeout_r + 8'd1;
                    end
                end

`ifdef LOADER_VERIFY_EN
                // One single read per word, with a one-cycle gap between reads.
                ST_VERIFY: begin
                    if (!wbm.wbm_cyc_o) begin
                        wbm.wbm_cyc_o <= 1'b1;
                        wbm.wbm_stb_o <= 1'b1;
                        timeout_r     <= 8'd0;
                    end else if (wbm.wbm_ack_i) begin
                        wbm.wbm_cyc_o <= 1'b0;
                        wbm.wbm_stb_o <= 1'b0;
                        wbm.wbm_adr_o <= wbm.wbm_adr_o + 32'd4;
                        rd_sum_r      <= rd_sum_r ^ wbm.wbm_dat_i;
                        if (word_cnt_r == LAST_WORD) begin
                            busy_o <= 1'b0;
                            if ((rd_sum_r ^ wbm.wbm_dat_i) == wr_sum_r) begin
                                state_r      <= ST_DONE;
                                debug_mode_o <= 1'b0;
                                done_o       <= 1'b1;
                            end else begin
                                state_r <= ST_ERROR;
                                error_o <= 1'b1;
                            end
                        end else begin
                            word_cnt_r <= word_cnt_r + CNT_W'(1);
                        end
                    end else if (timeout_r == TO_LAST) begin
                        state_r       <= ST_ERROR;
                        wbm.wbm_cyc_o <= 1'b0;
                        wbm.wbm_stb_o <= 1'b0;
                        busy_o        <= 1'b0;
                        error_o       <= 1'b1;
                    end else begin
                        timeout_r <= timeout_r + 8'd1;
                    end
                end
`endif

                default: begin
                    state_r       <= ST_IDLE;
                    wbm.wbm_cyc_o <= 1'b0;
                    wbm.wbm_stb_o <= 1'b0;
                    busy_o        <= 1'b0;
                end
            endcase
        end
    end

endmodule
